// File: rtl/apb_seq_pkg.sv
// Shared types and default widths for the APB command sequencer.
package apb_seq_pkg;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/apb_cmd_fifo.sv
// Synchronous command FIFO; pointers wrap naturally, count is one bit wider.
module apb_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 13
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata_c,
  output logic                     full_c,
  output logic                     empty_c,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Pointer and occupancy tracking; push and pop together leave count unchanged
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata_c = mem[rd_ptr];
  assign full_c  = (count == (PW+1)'(DEPTH));
  assign empty_c = (count == '0);

endmodule

// File: rtl/apb_cmd_sequencer.sv
// Buffers host commands and issues them one at a time to the APB master,
// returning read data / write echo with a timeout error over valid/ready.
module apb_cmd_sequencer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned AW      = apb_seq_pkg::AW,
  parameter int unsigned DW      = apb_seq_pkg::DW,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_wr,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_wr,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  output logic          newd,
  output logic          wr,
  output logic [AW-1:0] ain,
  output logic [DW-1:0] din,
  input  logic [DW-1:0] dout,
  input  logic          xfer_done
);

  import apb_seq_pkg::*;

  localparam int unsigned CW = 1 + AW + DW;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT);

  seq_state_e    state, state_d;
  logic [CW-1:0] head_c;
  logic          full_c, empty_c;
  logic [PW:0]   count;
  logic          push_c, pop_c;
  logic [TW-1:0] tcnt, tcnt_d;
  logic          newd_d, wr_d, rsp_valid_d, rsp_wr_d, rsp_err_d;
  logic [AW-1:0] ain_d;
  logic [DW-1:0] din_d, rsp_data_d;

  assign cmd_ready = !full_c;
  assign push_c    = cmd_valid && cmd_ready;

  apb_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (CW)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push    (push_c),
    .pop     (pop_c),
    .wdata   ({cmd_wr, cmd_addr, cmd_data}),
    .rdata_c (head_c),
    .full_c  (full_c),
    .empty_c (empty_c),
    .count   (count)
  );

  // Next-state and next-value logic for every registered output
  always_comb begin
    state_d     = state;
    pop_c       = 1'b0;
    newd_d      = 1'b0;
    wr_d        = wr;
    ain_d       = ain;
    din_d       = din;
    tcnt_d      = tcnt;
    rsp_valid_d = rsp_valid;
    rsp_wr_d    = rsp_wr;
    rsp_data_d  = rsp_data;
    rsp_err_d   = rsp_err;
    case (state)
      IDLE: begin
        if (!empty_c) begin
          pop_c                = 1'b1;
          {wr_d, ain_d, din_d} = head_c;
          newd_d               = 1'b1;
          state_d              = ISSUE;
        end
      end
      ISSUE: begin
        tcnt_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // Completion takes priority over a coincident timeout
        if (xfer_done) begin
          rsp_valid_d = 1'b1;
          rsp_wr_d    = wr;
          rsp_err_d   = 1'b0;
          rsp_data_d  = wr ? din : dout;
          state_d     = RESP;
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          rsp_valid_d = 1'b1;
          rsp_wr_d    = wr;
          rsp_err_d   = 1'b1;
          rsp_data_d  = '0;
          state_d     = RESP;
        end else begin
          tcnt_d = tcnt + TW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      tcnt      <= '0;
      newd      <= 1'b0;
      wr        <= 1'b0;
      ain       <= '0;
      din       <= '0;
      rsp_valid <= 1'b0;
      rsp_wr    <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_d;
      tcnt      <= tcnt_d;
      newd      <= newd_d;
      wr        <= wr_d;
      ain       <= ain_d;
      din       <= din_d;
      rsp_valid <= rsp_valid_d;
      rsp_wr    <= rsp_wr_d;
      rsp_data  <= rsp_data_d;
      rsp_err   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_apb_cmd_sequencer.sv
// Directed bench for apb_cmd_sequencer with a small APB slave model.
module tb_apb_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rstn;
  logic       cmd_valid, cmd_ready, cmd_wr;
  logic [3:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       rsp_valid, rsp_ready, rsp_wr, rsp_err;
  logic [7:0] rsp_data;
  logic       newd, wr;
  logic [3:0] ain;
  logic [7:0] din, dout;
  logic       xfer_done;

  int checks = 0;
  int errors = 0;

  // Slave model state
  int          cyc = 0;
  int          slave_delay = 2;
  logic [7:0]  slave_rdata = 8'h00;
  int          fire_at = -1;
  int          last_newd = -100;
  int          newd_cnt = 0;
  bit          stray_req = 1'b0;
  logic [12:0] issued[$];

  always #5 clk = ~clk;

  apb_cmd_sequencer #(
    .DEPTH(4), .AW(4), .DW(8), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wr(rsp_wr),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .newd(newd), .wr(wr), .ain(ain), .din(din), .dout(dout),
    .xfer_done(xfer_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic w, input logic [3:0] a, input logic [7:0] d);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_wr    = w;
    cmd_addr  = a;
    cmd_data  = d;
    while (!cmd_ready && n < 60) begin
      tick();
      n++;
    end
    check("push_ready", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (!rsp_valid && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
  endtask

  task automatic accept();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, "_ctl"}, 32'({rsp_valid, rsp_wr, rsp_err, newd, wr}), 32'd0);
    check({tag, "_ain_din"}, 32'({ain, din}), 32'd0);
    check({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
  endtask

  // APB slave model: records each issued command, answers after slave_delay cycles
  initial begin
    xfer_done = 1'b0;
    dout      = 8'h00;
    forever begin
      tick();
      cyc++;
      xfer_done = 1'b0;
      if (newd) begin
        check("newd_spacing", 32'((cyc - last_newd) >= 2), 32'd1);
        last_newd = cyc;
        newd_cnt++;
        issued.push_back({wr, ain, din});
        fire_at = (slave_delay > 0) ? cyc + slave_delay : -1;
      end
      if (cyc == fire_at) begin
        xfer_done = 1'b1;
        dout      = slave_rdata;
        fire_at   = -1;
      end
      if (stray_req) begin
        xfer_done = 1'b1;
        dout      = 8'hFF;
        stray_req = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int n0;
    bit saw_rsp;
    rstn      = 1'b0;
    cmd_valid = 1'b0;
    cmd_wr    = 1'b0;
    cmd_addr  = 4'h0;
    cmd_data  = 8'h00;
    rsp_ready = 1'b0;
    tick();
    tick();
    check_reset_outputs("rst");
    rstn = 1'b1;
    tick();

    // Single write: newd one cycle after the push edge, exactly one cycle wide
    slave_delay = 2;
    issued.delete();
    push(1'b1, 4'd3, 8'hA5);
    check("wr_newd_early", 32'(newd), 32'd0);
    tick();
    check("wr_newd", 32'(newd), 32'd1);
    check("wr_hold", 32'({wr, ain, din}), 32'({1'b1, 4'd3, 8'hA5}));
    tick();
    check("wr_newd_width", 32'(newd), 32'd0);
    wait_rsp("wr");
    check("wr_rsp", 32'({rsp_wr, rsp_err, rsp_data}), 32'({1'b1, 1'b0, 8'hA5}));
    check("wr_issued_n", 32'(issued.size()), 32'd1);
    accept();
    check("wr_rsp_cleared", 32'(rsp_valid), 32'd0);

    // Read: response carries slave data
    slave_delay = 3;
    slave_rdata = 8'h5C;
    issued.delete();
    push(1'b0, 4'd3, 8'h00);
    wait_rsp("rd");
    check("rd_rsp", 32'({rsp_wr, rsp_err, rsp_data}), 32'({1'b0, 1'b0, 8'h5C}));
    check("rd_issued", 32'(issued[0]), 32'({1'b0, 4'd3, 8'h00}));
    accept();

    // Fill: five back-to-back pushes leave the FIFO full
    slave_delay = 6;
    issued.delete();
    for (int i = 1; i <= 5; i++) push(1'b1, 4'(i), 8'(i * 17));
    check("fill_full", 32'(cmd_ready), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      wait_rsp("fill");
      check("fill_rsp", 32'({rsp_err, rsp_data}), 32'({1'b0, 8'(i * 17)}));
      accept();
    end
    check("fill_issued_n", 32'(issued.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      check("fill_order", 32'(issued[i]), 32'({1'b1, 4'(i + 1), 8'((i + 1) * 17)}));

    // Response stall with a second command queued
    slave_delay = 2;
    issued.delete();
    push(1'b1, 4'd7, 8'h3C);
    push(1'b1, 4'd8, 8'hC3);
    wait_rsp("stall");
    n0 = newd_cnt;
    for (int i = 0; i < 10; i++) begin
      check("stall_hold", 32'({rsp_valid, rsp_wr, rsp_err, rsp_data, newd}),
            32'({1'b1, 1'b1, 1'b0, 8'h3C, 1'b0}));
      tick();
    end
    check("stall_no_issue", 32'(newd_cnt), 32'(n0));
    accept();
    check("stall_turn_idle", 32'(newd), 32'd0);
    tick();
    check("stall_next_issue", 32'({newd, ain, din}), 32'({1'b1, 4'd8, 8'hC3}));
    wait_rsp("stall2");
    check("stall2_rsp", 32'(rsp_data), 32'hC3);
    accept();

    // Timeout: 16 WAIT cycles, then error response; stray pulses ignored
    slave_delay = 0;
    push(1'b0, 4'd5, 8'h00);
    n = 0;
    while (!newd && n < 20) begin
      tick();
      n++;
    end
    check("to_newd", 32'(newd), 32'd1);
    n = 0;
    while (!rsp_valid && n < 40) begin
      tick();
      n++;
    end
    check("to_cycles", 32'(n), 32'd17);
    check("to_rsp", 32'({rsp_valid, rsp_wr, rsp_err, rsp_data}), 32'({1'b1, 1'b0, 1'b1, 8'h00}));
    stray_req = 1'b1;
    tick();
    tick();
    tick();
    check("to_stray_resp", 32'({rsp_valid, rsp_err, rsp_data}), 32'({1'b1, 1'b1, 8'h00}));
    accept();
    n0 = newd_cnt;
    stray_req = 1'b1;
    repeat (4) tick();
    check("to_stray_idle", 32'({rsp_valid, newd}), 32'd0);
    check("to_stray_no_issue", 32'(newd_cnt), 32'(n0));

    // Reset mid-WAIT with two commands still queued
    slave_delay = 0;
    push(1'b1, 4'd9, 8'h99);
    push(1'b1, 4'hA, 8'hAA);
    push(1'b1, 4'hB, 8'hBB);
    check("mid_wait_held", 32'({wr, ain, din}), 32'({1'b1, 4'd9, 8'h99}));
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    check_reset_outputs("mrst");
    n0 = newd_cnt;
    saw_rsp = 1'b0;
    repeat (30) begin
      tick();
      if (rsp_valid) saw_rsp = 1'b1;
    end
    check("mrst_no_issue", 32'(newd_cnt), 32'(n0));
    check("mrst_no_rsp", 32'(saw_rsp), 32'd0);
    check("mrst_ready", 32'(cmd_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_cmd_sequencer.md
# apb_cmd_sequencer

Command front-end for the APB subsystem. Sits directly upstream of the APB top-level master port (`newd`/`wr`/`ain`/`din`/`dout`). It buffers host read/write commands in a small FIFO and issues them one at a time as single-cycle `newd` pulses. It holds address, data and direction stable until the transfer completes, then returns a per-command response (read data or write echo, plus timeout error) over a valid/ready channel.

## Interface
- `DEPTH`, 4: command FIFO entries; power of two, ≥2.
- `AW`, 4: address width.
- `DW`, 8: data width.
- `TIMEOUT`, 16: maximum WAIT cycles before a transfer is abandoned with an error; ≥2.

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rstn`  in  1  synchronous, active-low reset.
- `cmd_valid`  in  1  host command present.
- `cmd_ready`  out  1  FIFO can accept; equals not-full.
- `cmd_wr`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  AW  target address.
- `cmd_data`  in  DW  write data; ignored for reads.
- `rsp_valid`  out  1  response held.
- `rsp_ready`  in  1  host accepts response.
- `rsp_wr`  out  1  direction of the completed command.
- `rsp_data`  out  DW  read data, or write data echoed back for writes.
- `rsp_err`  out  1  transfer timed out.
- `newd`  out  1  one-cycle start pulse to the APB master.
- `wr`  out  1  direction to the master.
- `ain`  out  AW  address to the master.
- `din`  out  DW  write data to the master.
- `dout`  in  DW  read data from the master.
- `xfer_done`  in  1  one-cycle pulse when the APB access phase completes (psel & penable & pready).

## Operation
- **FIFO push** on `cmd_valid & cmd_ready`. There is no bypass: a push into a full FIFO is impossible because `cmd_ready` is 0.
- **Pop** occurs only in IDLE.
- **FSM states:** IDLE, ISSUE, WAIT, RESP.
- **IDLE:** if the FIFO is non-empty, pop the head into the hold registers (`wr`/`ain`/`din`) and go to ISSUE. Otherwise stay.
- **ISSUE:** `newd` = 1 for exactly this cycle; clear the timeout counter; go to WAIT.
- **WAIT:** hold `wr`/`ain`/`din` and increment the timeout counter.
  - On `xfer_done`, capture `rsp_data` = `dout` (read) or `din` (write), set `rsp_wr` = `wr` and `rsp_err` = 0, then go to RESP.
  - If the counter reaches `TIMEOUT-1` without `xfer_done`, set `rsp_err` = 1 and `rsp_data` = 0, then go to RESP.
  - If `xfer_done` and timeout occur in the same cycle, `xfer_done` wins.
- **RESP:** `rsp_valid` = 1 and the response fields stay stable until `rsp_ready`; on that handshake go to IDLE.
- **Stray `xfer_done`:** a pulse in IDLE, ISSUE or RESP is ignored.
- **Simultaneous push and pop:** both occur; the count is unchanged.
- **Pointers:** log2(`DEPTH`) bits and wrap naturally. The count is log2(`DEPTH`)+1 bits. Full when count == `DEPTH`; empty when count == 0.
- **Reset, including mid-transfer:**
  - State → IDLE and the FIFO is flushed.
  - Outputs return to reset values; an in-flight command is discarded with no response.
  - Reset values: `cmd_ready` = 1; `rsp_valid` = 0; `rsp_wr` = 0; `rsp_data` = 0; `rsp_err` = 0; `newd` = 0; `wr` = 0; `ain` = 0; `din` = 0.

## Timing
- All outputs are registered except `cmd_ready`, which is decoded from the count register.
- **Push to issue:** a command pushed at edge E0 into an empty FIFO in IDLE is popped at E1; `newd` is high between E1 and E2.
- **Completion:** `xfer_done` sampled high at edge Ek → `rsp_valid` is high after Ek.
- **Turnaround:** the response handshake at edge Er → IDLE; the next pop happens at Er+1. Minimum spacing is one IDLE cycle between consecutive `newd` pulses.
- **Pulse width:** `newd` is never high for two consecutive cycles.
- **Timeout:** `TIMEOUT` cycles in WAIT, counted from the first WAIT cycle.

## Structure
- **Package `apb_seq_pkg`:** FSM state enum (IDLE, ISSUE, WAIT, RESP) and the default width constants `AW`/`DW`.
- **Sub-module `apb_cmd_fifo`:** synchronous FIFO of width 1+`AW`+`DW`, parameterised depth, with push/pop/full/empty/count. The sequencer top contains the FSM, hold registers, response registers and timeout counter.

## Test plan
- **Single write:** push write `addr`=3, `data`=0xA5; model `xfer_done` 2 cycles after `newd` → exactly one `newd` pulse with `ain`=3, `din`=0xA5, `wr`=1; response `rsp_wr`=1, `rsp_data`=0xA5, `rsp_err`=0.
- **Read:** push read `addr`=3; model drives `dout`=0x5C with `xfer_done` → `rsp_data`=0x5C, `rsp_wr`=0, `rsp_err`=0.
- **Fill/back-pressure:** push 5 commands back-to-back with `DEPTH`=4 and the slave stalled → `cmd_ready` drops after the FIFO fills. The pop of the first command makes room for the fifth. All 5 issue in order, with `newd` pulses at least 2 cycles apart.
- **Response stall:** hold `rsp_ready`=0 for 10 cycles with a second command queued → no further `newd` until the handshake; `rsp_*` stay stable throughout.
- **Timeout:** never assert `xfer_done` with `TIMEOUT`=16 → RESP entered after 16 WAIT cycles with `rsp_err`=1 and `rsp_data`=0. A late stray `xfer_done` is ignored.
- **Reset mid-WAIT:** drop `rstn` for 1 cycle with 2 commands queued → all outputs take their reset values, `cmd_ready`=1, and no response or `newd` follows.
